// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS interrupt path.
// Holds the vector slot constants and the interrupt source index type.
package mips_pkg;

  localparam logic [31:0] VEC_BASE    = 32'h0000_01F0;
  localparam logic [31:0] VEC_STRIDE  = 32'h0000_0004;
  localparam logic [31:0] NO_INT_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    SRC_DONE1 = 2'd0,
    SRC_DONE2 = 2'd1,
    SRC_DONE3 = 2'd2,
    SRC_DONE4 = 2'd3
  } int_src_t;

  function automatic logic [3:0] src_onehot(input int_src_t src);
    return 4'b0001 << src;
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// 4-input priority encoder, lowest index wins.
// Ports:
//   req   - request vector, bit 0 has highest priority
//   idx   - index of the winning request (SRC_DONE1 when none)
//   valid - at least one request is set
module prio_enc4
  import mips_pkg::*;
(
  input  logic [3:0] req,
  output int_src_t   idx,
  output logic       valid
);

  always_comb begin
    idx = SRC_DONE1;
    if (req[0])      idx = SRC_DONE1;
    else if (req[1]) idx = SRC_DONE2;
    else if (req[2]) idx = SRC_DONE3;
    else if (req[3]) idx = SRC_DONE4;
    valid = |req;
  end

endmodule

// File: rtl/vectored_int.sv
// Interrupt vector unit for the single-cycle MIPS core.
// Latches rising edges of four peripheral completion lines as pending
// requests and presents the vector slot address of the highest-priority one.
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   int_ack  - controller acknowledge; retires the selected request
//   done1..4 - peripheral completion lines, done1 highest priority
//   int_addr - vector address of the selected request, NO_INT_ADDR if idle
//   int_req  - any request pending or arriving this cycle
//   int_id   - index of the selected source
module vectored_int
  import mips_pkg::*;
#(
  parameter logic [31:0] VEC_BASE_P    = VEC_BASE,
  parameter logic [31:0] VEC_STRIDE_P  = VEC_STRIDE,
  parameter logic [31:0] NO_INT_ADDR_P = NO_INT_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        int_ack,
  input  logic        done1,
  input  logic        done2,
  input  logic        done3,
  input  logic        done4,
  output logic [31:0] int_addr,
  output logic        int_req,
  output logic [1:0]  int_id
);

  logic [3:0] done_vec;
  logic [3:0] done_q;
  logic [3:0] pending;
  logic [3:0] rise;
  logic [3:0] eff;
  logic [3:0] clr;
  int_src_t   sel;
  logic       any;

  assign done_vec = {done4, done3, done2, done1};

  // done_q resets to 0, so a line already high at reset release is a rise.
  assign rise = done_vec & ~done_q;

  // New rises are folded in combinationally so they vector in their arrival cycle.
  assign eff = pending | rise;

  prio_enc4 u_prio (
    .req   (eff),
    .idx   (sel),
    .valid (any)
  );

  assign int_req  = any;
  assign int_id   = sel;
  assign int_addr = any ? (VEC_BASE_P + (VEC_STRIDE_P * 32'(sel))) : NO_INT_ADDR_P;

  // Only the vectored source is retired; a same-source rise in its ack cycle
  // is consumed together with it.
  assign clr = (int_ack && any) ? src_onehot(sel) : 4'b0000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q  <= 4'b0000;
      pending <= 4'b0000;
    end else begin
      done_q  <= done_vec;
      pending <= eff & ~clr;
    end
  end

endmodule

// File: tb/tb_vectored_int.sv
module tb_vectored_int;

  logic        clk;
  logic        reset_n;
  logic        int_ack;
  logic        done1, done2, done3, done4;
  logic [31:0] int_addr;
  logic        int_req;
  logic [1:0]  int_id;

  vectored_int dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .int_ack  (int_ack),
    .done1    (done1),
    .done2    (done2),
    .done3    (done3),
    .done4    (done4),
    .int_addr (int_addr),
    .int_req  (int_req),
    .int_id   (int_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        req;
    logic [1:0]  id;
    logic [3:0]  pend;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Monitor: the DUT output is valid every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (int_addr === e.addr) n_pass++;
        else $display("FAIL %s int_addr: got %h expected %h", e.name, int_addr, e.addr);
        n_chk++;
        if (int_req === e.req) n_pass++;
        else $display("FAIL %s int_req: got %b expected %b", e.name, int_req, e.req);
        n_chk++;
        if (int_id === e.id) n_pass++;
        else $display("FAIL %s int_id: got %0d expected %0d", e.name, int_id, e.id);
        n_chk++;
        if (dut.pending === e.pend) n_pass++;
        else $display("FAIL %s pending: got %b expected %b", e.name, dut.pending, e.pend);
      end
    end
  end

  task automatic push(input logic [31:0] ea, input logic er, input logic [1:0] ei,
                      input logic [3:0] ep, input string nm);
    exp_t e;
    e.addr = ea; e.req = er; e.id = ei; e.pend = ep; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] d, input logic a);
    {done4, done3, done2, done1} = d;
    int_ack = a;
  endtask

  // One clock cycle of stimulus with its expected response.
  task automatic cyc(input logic [3:0] d, input logic a, input logic [31:0] ea,
                     input logic er, input logic [1:0] ei, input logic [3:0] ep,
                     input string nm);
    @(posedge clk); #1;
    drive(d, a);
    push(ea, er, ei, ep, nm);
  endtask

  initial begin
    int guard;
    reset_n = 1'b0;
    drive(4'b0000, 1'b0);
    @(posedge clk); #1;
    push(32'h0, 1'b0, 2'd0, 4'b0000, "in_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++)
      cyc(4'b0000, 0, 32'h0, 0, 2'd0, 4'b0000, "idle");

    // done2 single pulse, acked later
    cyc(4'b0010, 0, 32'h1F4, 1, 2'd1, 4'b0000, "d2_arrive");
    cyc(4'b0000, 0, 32'h1F4, 1, 2'd1, 4'b0010, "d2_wait1");
    cyc(4'b0000, 0, 32'h1F4, 1, 2'd1, 4'b0010, "d2_wait2");
    cyc(4'b0000, 1, 32'h1F4, 1, 2'd1, 4'b0010, "d2_ack");
    cyc(4'b0000, 0, 32'h0,   0, 2'd0, 4'b0000, "d2_done");

    // done1 and done3 together, ack held two cycles
    cyc(4'b0101, 1, 32'h1F0, 1, 2'd0, 4'b0000, "d13_first");
    cyc(4'b0000, 1, 32'h1F8, 1, 2'd2, 4'b0100, "d13_second");
    cyc(4'b0000, 0, 32'h0,   0, 2'd0, 4'b0000, "d13_done");

    // done4 held for 10 cycles gives one request
    cyc(4'b1000, 0, 32'h1FC, 1, 2'd3, 4'b0000, "d4_c0");
    cyc(4'b1000, 0, 32'h1FC, 1, 2'd3, 4'b1000, "d4_c1");
    cyc(4'b1000, 1, 32'h1FC, 1, 2'd3, 4'b1000, "d4_c2_ack");
    for (int i = 3; i < 10; i++)
      cyc(4'b1000, 0, 32'h0, 0, 2'd0, 4'b0000, "d4_held");
    cyc(4'b0000, 0, 32'h0, 0, 2'd0, 4'b0000, "d4_fall");

    // ack in the arrival cycle of done1
    cyc(4'b0001, 1, 32'h1F0, 1, 2'd0, 4'b0000, "d1_ack_arrive");
    cyc(4'b0001, 0, 32'h0,   0, 2'd0, 4'b0000, "d1_held");
    cyc(4'b0000, 0, 32'h0,   0, 2'd0, 4'b0000, "d1_fall");

    // second rise merges into an existing pending bit
    cyc(4'b0010, 0, 32'h1F4, 1, 2'd1, 4'b0000, "merge_r1");
    cyc(4'b0000, 0, 32'h1F4, 1, 2'd1, 4'b0010, "merge_gap");
    cyc(4'b0010, 0, 32'h1F4, 1, 2'd1, 4'b0010, "merge_r2");
    cyc(4'b0000, 1, 32'h1F4, 1, 2'd1, 4'b0010, "merge_ack");
    cyc(4'b0000, 1, 32'h0,   0, 2'd0, 4'b0000, "ack_idle");
    cyc(4'b0000, 0, 32'h0,   0, 2'd0, 4'b0000, "ack_idle_after");

    // all four at once, ack held: retired in priority order
    cyc(4'b1111, 1, 32'h1F0, 1, 2'd0, 4'b0000, "all_c0");
    cyc(4'b0000, 1, 32'h1F4, 1, 2'd1, 4'b1110, "all_c1");
    cyc(4'b0000, 1, 32'h1F8, 1, 2'd2, 4'b1100, "all_c2");
    cyc(4'b0000, 1, 32'h1FC, 1, 2'd3, 4'b1000, "all_c3");
    cyc(4'b0000, 0, 32'h0,   0, 2'd0, 4'b0000, "all_done");

    // async reset with pending = 1010
    cyc(4'b1010, 0, 32'h1F4, 1, 2'd1, 4'b0000, "rst_setup");
    cyc(4'b0000, 0, 32'h1F4, 1, 2'd1, 4'b1010, "rst_pending");
    @(posedge clk); #1;
    drive(4'b0000, 1'b0);
    #2 reset_n = 1'b0;
    push(32'h0, 0, 2'd0, 4'b0000, "async_reset");

    // done3 high while reset is held, then released
    cyc(4'b0100, 0, 32'h1F8, 1, 2'd2, 4'b0000, "rise_in_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    push(32'h1F8, 1, 2'd2, 4'b0000, "rise_at_release");
    cyc(4'b0100, 1, 32'h1F8, 1, 2'd2, 4'b0100, "release_ack");
    cyc(4'b0000, 0, 32'h0,   0, 2'd0, 4'b0000, "release_done");

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
